// File: rtl/wired_refill_arbiter.sv
// wired_refill_arbiter: shares the single cache-refill bus port between NUM_REQ
// miss requesters. Holds one transaction outstanding at a time, locks the
// winner until the last response beat, and drains beats of a flushed owner.
// Optional build macro: WIRED_REFILL_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin.
module wired_refill_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int REQ_WIDTH  = 64,
    parameter int RESP_WIDTH = 160
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ-1:0][REQ_WIDTH-1:0]   req_i,
    input  logic [NUM_REQ-1:0]                  flush_i,
    output logic [NUM_REQ-1:0]                  resp_valid_o,
    output logic                                resp_last_o,
    output logic [RESP_WIDTH-1:0]               resp_o,
    output logic                                m_req_valid_o,
    input  logic                                m_req_ready_i,
    output logic [REQ_WIDTH-1:0]                m_req_o,
    input  logic                                m_resp_valid_i,
    input  logic                                m_resp_last_i,
    input  logic [RESP_WIDTH-1:0]               m_resp_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   owner_q;
    logic               dropped_q;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [NUM_REQ-1:0] req_masked;
    logic               owner_flush;

    // A flushing requester is not eligible for a grant in the same cycle.
    assign req_masked  = req_valid_i & ~flush_i;
    assign owner_flush = flush_i[owner_q];
    assign resp_o      = m_resp_i;

    // State register.
    // NOTE: clocked blocks use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant -> issue -> wait for the last beat -> idle.
    // NOTE: the default assignment first means no path leaves state_d unassigned, so no latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = ISSUE;
            ISSUE:   if (m_req_ready_i) state_d = WAIT;
            WAIT:    if (m_resp_valid_i && m_resp_last_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef WIRED_REFILL_ARB_FIXED_PRIO_EN
    // Fixed priority: scanning downward lets the lowest eligible index win.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_masked[i]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_q;

    // Round-robin: priority order rr, rr+1, ... wrapping; scanning the order
    // backwards lets the first eligible requester overwrite the others.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (req_masked[idx]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

    // Pointer moves just past each winner so the other requesters go next.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
        end else if (state_q == IDLE && grant_any) begin
            rr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    // Outputs: grant strobe in IDLE, bus request in ISSUE, owner-routed beats in WAIT.
    always_comb begin
        req_ready_o   = '0;
        m_req_valid_o = 1'b0;
        resp_valid_o  = '0;
        resp_last_o   = 1'b0;
        case (state_q)
            // A grant during reset would be discarded, so do not advertise it.
            IDLE:  if (grant_any && !rst) req_ready_o[grant_idx] = 1'b1;
            ISSUE: m_req_valid_o = 1'b1;
            WAIT: begin
                if (m_resp_valid_i) begin
                    resp_valid_o[owner_q] = !dropped_q && !owner_flush;
                    resp_last_o           = m_resp_last_i;
                end
            end
            default: ;
        endcase
    end

    // Transaction context: payload and owner captured at grant, flush remembered
    // until the adapter finishes, since the bus transaction cannot be aborted.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_req_o   <= '0;
            owner_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        m_req_o   <= req_i[grant_idx];
                        owner_q   <= grant_idx;
                        dropped_q <= 1'b0;
                    end
                end
                ISSUE, WAIT: if (owner_flush) dropped_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // The adapter only returns beats for the transaction it accepted.
    a_resp_only_in_wait: assert property (
        @(posedge clk) disable iff (rst) m_resp_valid_i |-> (state_q == WAIT)
    );

endmodule

// File: tb/tb_wired_refill_arbiter.sv
// Testbench for wired_refill_arbiter: directed scenarios plus randomized traffic.
// A transaction-level reference model predicts every visible output event;
// an independent monitor pops and compares them when the DUT presents them.
`timescale 1ns/1ps
module tb_wired_refill_arbiter;

    localparam int N  = 2;
    localparam int RW = 64;
    localparam int PW = 160;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid_i;
    logic [N-1:0]         req_ready_o;
    logic [N-1:0][RW-1:0] req_i;
    logic [N-1:0]         flush_i;
    logic [N-1:0]         resp_valid_o;
    logic                 resp_last_o;
    logic [PW-1:0]        resp_o;
    logic                 m_req_valid_o;
    logic                 m_req_ready_i;
    logic [RW-1:0]        m_req_o;
    logic                 m_resp_valid_i;
    logic                 m_resp_last_i;
    logic [PW-1:0]        m_resp_i;

    wired_refill_arbiter #(.NUM_REQ(N), .REQ_WIDTH(RW), .RESP_WIDTH(PW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_i         (req_i),
        .flush_i       (flush_i),
        .resp_valid_o  (resp_valid_o),
        .resp_last_o   (resp_last_o),
        .resp_o        (resp_o),
        .m_req_valid_o (m_req_valid_o),
        .m_req_ready_i (m_req_ready_i),
        .m_req_o       (m_req_o),
        .m_resp_valid_i(m_resp_valid_i),
        .m_resp_last_i (m_resp_last_i),
        .m_resp_i      (m_resp_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp_v);
        end
    endtask

    // Expected visible event for one cycle.
    typedef struct {
        int            cyc;
        logic [N-1:0]  ready;
        logic          m_valid;
        logic [RW-1:0] m_req;
        logic [N-1:0]  resp_valid;
        logic          resp_last;
        logic [PW-1:0] resp_data;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: is a transaction in flight, has the bus taken it, who owns it.
    bit            busy;
    bit            issued;
    bit            dropped;
    int            owner;
    int            rr;
    logic [RW-1:0] pend;
    int            beats_left;

    function automatic int pick(input logic [N-1:0] m);
`ifdef WIRED_REFILL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (m[i]) return i;
`else
        for (int k = 0; k < N; k++) if (m[(rr + k) % N]) return (rr + k) % N;
`endif
        return -1;
    endfunction

    // Drive one cycle of inputs and record what the DUT should show in it.
    task automatic step(input logic [N-1:0] rv, input logic [N-1:0] fl,
                        input logic [N-1:0][RW-1:0] rq, input logic mr,
                        input logic bv, input logic bl, input logic [PW-1:0] bd);
        exp_t e;
        int   g;
        bit   any;
        @(posedge clk); #1;
        req_valid_i = rv; flush_i = fl; req_i = rq; m_req_ready_i = mr;
        m_resp_valid_i = bv; m_resp_last_i = bl; m_resp_i = bd;
        e.cyc = cyc; e.ready = '0; e.m_valid = 1'b0; e.m_req = '0;
        e.resp_valid = '0; e.resp_last = 1'b0; e.resp_data = '0;
        any = 0;
        if (!busy) begin
            g = pick(rv & ~fl);
            if (g >= 0) begin
                e.ready[g] = 1'b1; any = 1;
                busy = 1; issued = 0; dropped = 0; owner = g; pend = rq[g];
                rr = (g + 1) % N;
            end
        end else if (!issued) begin
            e.m_valid = 1'b1; e.m_req = pend; any = 1;
            if (fl[owner]) dropped = 1;
            if (mr) issued = 1;
        end else begin
            if (fl[owner]) dropped = 1;
            if (bv) begin
                if (!dropped) begin
                    e.resp_valid[owner] = 1'b1; e.resp_last = bl; e.resp_data = bd; any = 1;
                end
                if (bl) busy = 0;
            end
        end
        if (any) exp_q.push_back(e);
    endtask

    // Shorthands for directed stimulus.
    logic [N-1:0][RW-1:0] rq0;
    task automatic idle_req(input logic [N-1:0] rv, input logic [N-1:0] fl);
        step(rv, fl, rq0, 1'b0, 1'b0, 1'b0, '0);
    endtask
    task automatic bus_accept(input logic ready);
        step('0, '0, rq0, ready, 1'b0, 1'b0, '0);
    endtask
    task automatic beat(input logic [N-1:0] rv, input logic [N-1:0] fl, input logic last, input int tag);
        step(rv, fl, rq0, 1'b0, 1'b1, last, {128'hBEEF_0000, 32'(tag)});
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid_i = '0; flush_i = '0; m_req_ready_i = 1'b0;
        m_resp_valid_i = 1'b0; m_resp_last_i = 1'b0;
        busy = 0; issued = 0; dropped = 0; owner = 0; rr = 0; beats_left = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 256'(req_ready_o), 256'(0));
        check("rst_m_req_valid", 256'(m_req_valid_o), 256'(0));
        check("rst_resp_valid", 256'(resp_valid_o), 256'(0));
        check("rst_resp_last", 256'(resp_last_o), 256'(0));
        check("rst_m_req", 256'(m_req_o), 256'(0));
    endtask

    // Monitor: compares whenever the DUT shows a grant, a bus request or a beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL missing_event @cyc %0d: DUT idle, expected event from cyc %0d", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (req_ready_o != '0 || m_req_valid_o || resp_valid_o != '0) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_event @cyc %0d: ready=%b m_valid=%b resp_valid=%b, expected none",
                             cyc, req_ready_o, m_req_valid_o, resp_valid_o);
                end else begin
                    e = exp_q.pop_front();
                    check("req_ready", 256'(req_ready_o), 256'(e.ready));
                    check("m_req_valid", 256'(m_req_valid_o), 256'(e.m_valid));
                    if (e.m_valid) check("m_req", 256'(m_req_o), 256'(e.m_req));
                    check("resp_valid", 256'(resp_valid_o), 256'(e.resp_valid));
                    if (e.resp_valid != '0) begin
                        check("resp_last", 256'(resp_last_o), 256'(e.resp_last));
                        check("resp_data", 256'(resp_o), 256'(e.resp_data));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]  rv, fl;
        logic          mr, bv, bl;
        logic [PW-1:0] bd;
        logic [N-1:0][RW-1:0] rq;
        int            guard;

        rst = 1'b1; req_valid_i = '0; flush_i = '0; req_i = '0; m_req_ready_i = 1'b0;
        m_resp_valid_i = 1'b0; m_resp_last_i = 1'b0; m_resp_i = '0;
        busy = 0; issued = 0; dropped = 0; owner = 0; rr = 0; beats_left = 0;
        rq0 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("init_req_ready", 256'(req_ready_o), 256'(0));
        check("init_m_req_valid", 256'(m_req_valid_o), 256'(0));
        check("init_m_req", 256'(m_req_o), 256'(0));

        // Single request from requester 0, four beats.
        rq0[0] = 64'hA5; rq0[1] = 64'h5A;
        idle_req(2'b01, 2'b00);
        bus_accept(1'b1);
        for (int i = 0; i < 4; i++) beat('0, '0, i == 3, i);
        idle_req('0, '0);

        // Contention: both valid throughout, four back-to-back transactions.
        for (int t = 0; t < 4; t++) begin
            rq0[0] = 64'(t * 16 + 1); rq0[1] = 64'(t * 16 + 2);
            idle_req(2'b11, 2'b00);
            step(2'b11, '0, rq0, 1'b1, 1'b0, 1'b0, '0);
            beat(2'b11, '0, 1'b1, 100 + t);
        end
        idle_req('0, '0);

        // Backpressure: adapter stalls for five cycles.
        rq0[1] = 64'hDEAD_BEEF;
        idle_req(2'b10, 2'b00);
        rq0[1] = 64'h1111;
        for (int i = 0; i < 5; i++) step(2'b11, '0, rq0, 1'b0, 1'b0, 1'b0, '0);
        bus_accept(1'b1);
        beat('0, '0, 1'b0, 200);
        beat('0, '0, 1'b1, 201);

        // Owner flush on beat 2 of 4; next grant the cycle after beat 4.
        rq0[1] = 64'hF1;
        idle_req(2'b10, 2'b00);
        bus_accept(1'b1);
        beat('0, 2'b00, 1'b0, 300);
        beat('0, 2'b10, 1'b0, 301);
        beat('0, 2'b00, 1'b0, 302);
        beat('0, 2'b00, 1'b1, 303);
        rq0[0] = 64'hC0;
        idle_req(2'b01, 2'b00);
        bus_accept(1'b1);
        beat('0, '0, 1'b1, 304);

        // Flush on the last beat while requester 1 asks; it wins next cycle.
        rq0[0] = 64'hC1; rq0[1] = 64'hD1;
        idle_req(2'b01, 2'b00);
        bus_accept(1'b1);
        beat('0, 2'b00, 1'b0, 400);
        beat(2'b10, 2'b01, 1'b1, 401);
        idle_req(2'b10, 2'b00);
        bus_accept(1'b1);
        beat('0, '0, 1'b1, 402);

        // Reset in the middle of a response, then contention restarts at requester 0.
        idle_req(2'b01, 2'b00);
        bus_accept(1'b1);
        beat('0, '0, 1'b0, 500);
        do_reset();
        rq0[0] = 64'hE0; rq0[1] = 64'hE1;
        idle_req(2'b11, 2'b00);
        bus_accept(1'b1);
        beat('0, '0, 1'b1, 501);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rv = N'($urandom);
            fl = ($urandom % 6 == 0) ? N'($urandom) : '0;
            for (int j = 0; j < N; j++) rq[j] = {$urandom, $urandom};
            bd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            mr = 1'b0; bv = 1'b0; bl = 1'b0;
            if (busy && !issued) begin
                mr = ($urandom % 3 != 0);
                if (mr) beats_left = 1 + int'($urandom % 4);
            end else if (busy && issued) begin
                bv = ($urandom % 3 != 0);
                bl = bv && (beats_left == 1);
                if (bv) beats_left--;
            end
            step(rv, fl, rq, mr, bv, bl, bd);
        end

        // Drain whatever transaction is still open.
        guard = 0;
        while (busy && guard < 50) begin
            mr = 1'b0; bv = 1'b0; bl = 1'b0;
            if (!issued) begin
                mr = 1'b1;
                beats_left = 1;
            end else begin
                bv = 1'b1;
                bl = (beats_left == 1);
                beats_left--;
            end
            step('0, '0, rq0, mr, bv, bl, '0);
            guard++;
        end
        if (busy) begin
            n_checks++; n_fail++;
            $display("FAIL drain: transaction still open after %0d cycles, expected closed", guard);
        end
        idle_req('0, '0);
        @(negedge clk);
        @(negedge clk);
        check("queue_empty", 256'(exp_q.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
